// File: rtl/dsp_pkg.sv
// Shared DSP constants: rounding modes for halved results and the
// address-width helper used to size RAM pointers from a depth.
package dsp_pkg;

  localparam int RND_FLOOR = 0;
  localparam int RND_ZERO  = 1;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ram_pair_sum_mem.sv
// Sample storage for ram_pair_sum: one write port and two registered read
// ports. A read and a write to the same entry on one edge returns the old data.
module ram_pair_sum_mem
  import dsp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             write,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset here: contents stay undefined until written.
  always_ff @(posedge clock) begin
    if (write) mem[wr_addr] <= wr_data;
    if (rd_en) begin
      rd_data1 <= mem[rd_addr1];
      rd_data2 <= mem[rd_addr2];
    end
  end

endmodule

// File: rtl/ram_pair_sum.sv
// Circular sample RAM that reads two taps and returns their halved sum.
// Optional macro RAM_PAIR_SUM_SUBTRACT_EN adds port 'sub' to form (a-b)/2.
module ram_pair_sum
  import dsp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int RND   = RND_ZERO,
  parameter int REL   = 0,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             write,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
`ifdef RAM_PAIR_SUM_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             sum_valid,
  output logic [AW-1:0]    wr_ptr,
  output logic             primed
);

  logic [AW:0]      wr_cnt;
  logic [AW-1:0]    ra1, ra2;
  logic [WIDTH-1:0] op_a, op_b;
  logic             v1;
  logic             sub1;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] half;

  // Relative mode counts back from the newest sample (offset 0 = last write).
  always_comb begin
    ra1 = rd_addr1;
    ra2 = rd_addr2;
    if (REL != 0) begin
      ra1 = wr_ptr - AW'(1) - rd_addr1;
      ra2 = wr_ptr - AW'(1) - rd_addr2;
    end
  end

  // Counter saturates at DEPTH; its MSB is exactly the primed flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      wr_cnt <= '0;
    end else if (write) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (!wr_cnt[AW]) wr_cnt <= wr_cnt + (AW+1)'(1);
    end
  end

  assign primed = wr_cnt[AW];

  ram_pair_sum_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clock    (clock),
    .write    (write),
    .wr_addr  (wr_ptr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr1 (ra1),
    .rd_addr2 (ra2),
    .rd_data1 (op_a),
    .rd_data2 (op_b)
  );

`ifdef RAM_PAIR_SUM_SUBTRACT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sub1 <= 1'b0;
    else          sub1 <= sub;
  end
`else
  assign sub1 = 1'b0;
`endif

  // The WIDTH+1 sum halved back to WIDTH bits cannot overflow.
  always_comb begin
    if (sub1) s = {op_a[WIDTH-1], op_a} - {op_b[WIDTH-1], op_b};
    else      s = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
    half = s[WIDTH:1];
    if (RND != RND_FLOOR) half = half + WIDTH'(s[WIDTH] & s[0]);
  end

  // Valid/ready: no ready exists. Every rd_en is accepted; sum_valid is a
  // one-cycle strobe two edges later, and sum holds between strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1        <= 1'b0;
      sum_valid <= 1'b0;
      sum       <= '0;
    end else begin
      v1        <= rd_en;
      sum_valid <= v1;
      if (v1) sum <= half;
    end
  end

endmodule

// File: doc/ram_pair_sum.md
RAM_PAIR_SUM -- requirements
Module: ram_pair_sum

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample and sum width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: RAM entries; power of two, 4..256; AW = log2(DEPTH).
REQ-003 SHALL have parameter RND, default 1: 0 = halve by floor, 1 = halve rounding toward zero.
REQ-004 SHALL have parameter REL, default 0: 0 = absolute read addresses, 1 = read addresses are offsets behind the write pointer.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port write, input, 1: write strobe.
REQ-008 SHALL have port wr_data, input, WIDTH: signed sample to store.
REQ-009 SHALL have port rd_en, input, 1: read-pair request.
REQ-010 SHALL have port rd_addr1 and rd_addr2, input, AW each: pair addresses or offsets.
REQ-011 SHALL have port sum, output, WIDTH: signed halved pair result.
REQ-012 SHALL have port sum_valid, output, 1: sum updated this cycle.
REQ-013 SHALL have port wr_ptr, output, AW: next write location.
REQ-014 SHALL have port primed, output, 1: DEPTH writes completed since reset.

Function
REQ-015 SHALL write wr_data to ram[wr_ptr] on a clock edge with write=1, then increment wr_ptr modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-016 SHALL resolve address x as x when REL=0, and as (wr_ptr-1-x) mod DEPTH when REL=1, using wr_ptr sampled in the rd_en cycle.
REQ-017 SHALL register operands a and b from RAM one edge after rd_en; same-edge write to the read address SHALL return the old data.
REQ-018 SHALL form s = sext(a) + sext(b), or sext(a) - sext(b) per REQ-027, in WIDTH+1 bits.
REQ-019 SHALL output s[WIDTH:1] when RND=0, and s[WIDTH:1] + (s[WIDTH] & s[0]) when RND=1; the result never overflows WIDTH bits.
REQ-020 SHALL present sum and sum_valid=1 two edges after rd_en=1; the pipeline is fully pipelined, one request per cycle, no stall.
REQ-021 SHALL hold sum at its last value when sum_valid=0.
REQ-022 SHALL count writes in a saturating counter; primed rises on the edge of the DEPTH-th write and stays high until reset.
REQ-023 SHALL allow rd_addr1 = rd_addr2; the result is then that sample (rounded per RND), or 0 when subtracting.

Reset
REQ-024 SHALL, while reset_n=0, force sum=0, sum_valid=0, wr_ptr=0, primed=0 and clear the write counter and valid pipeline, independent of clock.
REQ-025 SHALL discard requests in flight at reset assertion; RAM contents are not reset and are undefined until written.
REQ-026 SHALL accept write and rd_en on the first rising edge after reset_n deasserts.

Configuration
REQ-027 SHALL provide macro RAM_PAIR_SUM_SUBTRACT_EN: when defined, add input port sub (1 bit, sampled with rd_en and pipelined alongside it); sub=1 selects a-b for antisymmetric taps. When undefined, no sub port exists and the block always adds.

Structure
REQ-028 SHALL place rounding-mode constants (RND_FLOOR=0, RND_ZERO=1) and the address-width function in shared package dsp_pkg.
REQ-029 SHALL isolate storage in sub-module ram_pair_sum_mem: one write port and two registered read ports.

Verification (WIDTH=16, DEPTH=16)
REQ-030 SHALL cover: RND=1, ram[2]=3, ram[5]=-6, rd_en (2,5) -> two edges later sum=-1 (s=-3), sum_valid=1 for one cycle.
REQ-031 SHALL cover: RND=0, same data -> sum=-2; both operands 0x8000 -> sum=0x8000; both 0x7FFF -> 0x7FFF.
REQ-032 SHALL cover: 17 writes -> wr_ptr = 1, primed high after the 16th write, write 17 lands in ram[0].
REQ-033 SHALL cover: REL=1 after writes 10,20,30 (wr_ptr=3), offsets (0,2) -> sum=20 (30+10)/2.
REQ-034 SHALL cover: reset_n low between rd_en and result -> sum_valid stays 0, sum=0, wr_ptr=0, primed=0.
REQ-035 SHALL cover: with RAM_PAIR_SUM_SUBTRACT_EN, sub=1, a=0x7FFF, b=0x8000 -> sum=0x7FFF; write and read of the same address on the same edge returns the old data.
